// File: rtl/ann_pkg.sv
// Shared types and default widths for the ANN datapath blocks.
package ann_pkg;

  localparam int ANN_DATA_W    = 8;
  localparam int ANN_FRAC_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } ann_state_e;

  typedef enum logic {
    ACT_IDENTITY,
    ACT_RELU
  } ann_act_e;

endpackage

// File: rtl/ann_shift_sat.sv
// Combinational ReLU, arithmetic rescale and saturation of a wide Q-format
// accumulator down to a DATA_W result.
module ann_shift_sat
  import ann_pkg::*;
#(
  parameter int ACC_W     = 20,
  parameter int DATA_W    = ANN_DATA_W,
  parameter int FRAC_BITS = ANN_FRAC_BITS
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic                     relu,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);

  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  logic signed [ACC_W-1:0] s;
  logic signed [ACC_W-1:0] r;

  always_comb begin
    s   = (relu && acc < 0) ? '0 : acc;
    // Arithmetic shift floors toward minus infinity for negative sums.
    r   = s >>> FRAC_BITS;
    sat = 1'b0;
    y   = r[DATA_W-1:0];
    if (r > Y_MAX) begin
      y   = Y_MAX[DATA_W-1:0];
      sat = 1'b1;
    end else if (r < Y_MIN) begin
      y   = Y_MIN[DATA_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/ann_neuron_mac.sv
// Single-neuron MAC: accumulates N_INPUTS signed x*w products onto a bias,
// then applies activation, rescale and saturation to one output beat.
module ann_neuron_mac
  import ann_pkg::*;
#(
  parameter int DATA_W    = ANN_DATA_W,
  parameter int FRAC_BITS = ANN_FRAC_BITS,
  parameter int N_INPUTS  = 4,
  parameter int ACC_W     = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_w,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     act_relu,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_y,
  output logic                     out_sat,
  output ann_state_e               fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // ready/valid come from registered state only and the producer holds its
  // data until the transfer.

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

  ann_state_e              state_q, state_d;
  ann_act_e                mode_q, mode_now;
  logic [CNT_W-1:0]        count_q;
  logic signed [ACC_W-1:0] acc_q;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext, acc_base, sum;
  logic signed [DATA_W-1:0]   sat_y;
  logic                       sat_flag;
  logic                       beat, last;

  assign in_ready  = (state_q != OUTPUT);
  assign out_valid = (state_q == OUTPUT);
  assign fsm_state = state_q;

  assign prod     = in_x * in_w;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W-FRAC_BITS){bias[DATA_W-1]}}, bias, {FRAC_BITS{1'b0}}};
  // The first beat seeds the sum from the bias instead of the stale accumulator.
  assign acc_base = (state_q == IDLE) ? bias_ext : acc_q;
  assign sum      = acc_base + prod_ext;
  assign mode_now = (state_q == IDLE) ? (act_relu ? ACT_RELU : ACT_IDENTITY) : mode_q;

  assign beat = in_valid && in_ready;
  assign last = beat && (count_q == LAST_IDX);

  ann_shift_sat #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_shift_sat (
    .acc (sum),
    .relu(mode_now == ACT_RELU),
    .y   (sat_y),
    .sat (sat_flag)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat) state_d = last ? OUTPUT : ACCUM;
      ACCUM:   if (last) state_d = OUTPUT;
      OUTPUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= ACT_IDENTITY;
      out_y   <= '0;
      out_sat <= 1'b0;
    end else if (beat) begin
      acc_q   <= sum;
      count_q <= count_q + CNT_W'(1);
      if (state_q == IDLE) mode_q <= mode_now;
      if (last) begin
        out_y   <= sat_y;
        out_sat <= sat_flag;
      end
    end else if (state_q == OUTPUT && out_ready) begin
      acc_q   <= '0;
      count_q <= '0;
    end
  end

endmodule

// File: doc/ann_neuron_mac.md
# ann_neuron_mac

Parametrised single-neuron compute block for the ANN datapath. It consumes N_INPUTS signed (x, w) pairs over a valid/ready stream and accumulates their products onto a bias. It then applies the selected activation, rescales, saturates, and presents one signed result on a valid/ready output. It generalises the plain combinational adder stage into a sequential, width-configurable MAC with activation and saturation.

## Interface
- DATA_W, 8: width of x, w, bias and y; all signed two's complement.
- FRAC_BITS, 4: fractional bits of x, w, bias and y (Q format); products carry 2*FRAC_BITS.
- N_INPUTS, 4: pairs per neuron evaluation; must be ≥1.
- ACC_W, 20: accumulator width; must be ≥ 2*DATA_W + clog2(N_INPUTS) + 1, so the accumulator never overflows.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  x/w pair present.
- in_ready  out  1  block accepts a pair this cycle.
- in_x  in  DATA_W  signed activation input.
- in_w  in  DATA_W  signed weight.
- bias  in  DATA_W  signed bias; sampled with the first beat of an evaluation.
- act_relu  in  1  1 = ReLU, 0 = identity; sampled with the first beat.
- out_valid  out  1  result held on out_y.
- out_ready  in  1  consumer takes result.
- out_y  out  DATA_W  signed saturated result.
- out_sat  out  1  result was clipped to the DATA_W range.

## Operation
- States:
  - IDLE: count=0, in_ready=1.
  - ACCUM: 1≤count<N_INPUTS, in_ready=1.
  - OUTPUT: out_valid=1, in_ready=0.
- A beat is accepted when in_valid && in_ready. Gaps in in_valid are allowed and change nothing.
- First beat (IDLE):
  - acc ← sext(bias) <<< FRAC_BITS, plus sext(in_x*in_w).
  - Latch act_relu.
  - If N_INPUTS=1, go to OUTPUT; otherwise go to ACCUM.
- Later beats: acc ← acc + sext(in_x*in_w). Product is full 2*DATA_W signed, sign-extended to ACC_W.
- Last beat (count reaches N_INPUTS): the final sum s = acc + product is computed combinationally and processed as follows before registering:
  - If ReLU is latched and s<0, s=0.
  - r = s >>> FRAC_BITS (arithmetic shift, rounds toward −∞).
  - Clip r to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; out_sat=1 if clipped.
  - Register r into out_y and out_sat, and go to OUTPUT.
- OUTPUT: out_y and out_sat are stable. On out_valid && out_ready, go to IDLE; the acc and count registers clear.
- Reset (any time, including mid-evaluation or in OUTPUT):
  - state=IDLE, acc=0, count=0, latched mode=identity.
  - out_valid=0, out_y=0, out_sat=0, in_ready=1 once rst deasserts.
  - Any partial sum is discarded.

## Timing
- in_ready and out_valid are decoded from registered state only. There is no combinational in→out path.
- Latency: out_valid rises on the edge that accepts the Nth beat, so it is visible in the next cycle.
- Minimum period per evaluation: N_INPUTS + 1 cycles, because input is blocked during OUTPUT.
- Holding out_ready low stalls OUTPUT indefinitely, with outputs held.
- in_valid asserted during OUTPUT is ignored (in_ready=0); the upstream source holds the beat.
- out_y and out_sat change only on entry to OUTPUT or on reset.

## Structure
- Shared package ann_pkg:
  - state enum {IDLE, ACCUM, OUTPUT}.
  - act-mode enum.
  - Default constants for DATA_W and FRAC_BITS, shared with other ANN layers.
- One sub-module, ann_shift_sat: a combinational ReLU, arithmetic shift and saturate, parametrised by ACC_W, DATA_W and FRAC_BITS, with outputs y and sat. It is reused by future layer blocks.
- Top level holds the FSM, beat counter, accumulator and output registers.

## Test plan
Defaults: DATA_W=8, FRAC_BITS=4, N_INPUTS=4, ACC_W=20.
- Basic: x={16,16,16,16}, w={16,32,−16,0}, bias=0, ReLU → out_y=32, out_sat=0, out_valid in the cycle after the 4th beat.
- Activation: x all 16, w all −16, bias=0 → ReLU: out_y=0; identity: out_y=−64; out_sat=0 in both cases.
- Saturation: x=w=127 ×4 → out_y=127, out_sat=1. x=127, w=−128 ×4, identity → out_y=−128, out_sat=1.
- Bias and gaps: bias=16, x all 0, one-cycle in_valid gaps between beats → out_y=16, count unaffected by gaps.
- Backpressure: out_ready low 5 cycles → out_y held, in_ready=0, a pending in_valid is not consumed. out_ready high → IDLE next cycle, then the next evaluation proceeds correctly.
- Reset mid-op: after 2 beats pulse rst asynchronously between edges → all outputs 0 immediately. Then replay the basic case → out_y=32.
